// File: rtl/parallel_lane_rr_arbiter_pkg.sv
// Shared definitions for the parallel lane round-robin arbiter.
// Holds the FSM state encoding, default parameter values and helper
// functions that derive the word width, requester count, counter
// width and burst limit from the log2 parameters S, R and L.
package parallel_lane_rr_arbiter_pkg;

  // Two-state controller: waiting for arbitration, or streaming a burst
  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_t;

  localparam int DEF_S = 3;
  localparam int DEF_R = 2;
  localparam int DEF_L = 2;

  // Lane word width W = 2**S
  function automatic int lane_width(input int s);
    return 1 << s;
  endfunction

  // Requester count N = 2**R
  function automatic int req_count(input int r);
    return 1 << r;
  endfunction

  // Burst counter width CNT_W = L+1, wide enough to hold 2**L itself
  function automatic int cnt_width(input int l);
    return l + 1;
  endfunction

  // Maximum number of words per grant, 2**L
  function automatic int burst_limit(input int l);
    return 1 << l;
  endfunction

endpackage

// File: rtl/parallel_lane_rr_arbiter_rr_pick.sv
// Round-robin winner selection.
// Ports:
//   req    - per-requester request vector (2**R bits)
//   ptr    - highest-priority index this round
//   any    - at least one request is present
//   winner - first requesting index at or after ptr, wrapping around
module rr_pick
  import parallel_lane_rr_arbiter_pkg::*;
#(
  parameter int R = DEF_R
) (
  input  logic [req_count(R)-1:0] req,
  input  logic [R-1:0]            ptr,
  output logic                    any,
  output logic [R-1:0]            winner
);

  localparam int N = req_count(R);

  logic [N-1:0]   mask;
  logic [2*N-1:0] dbl;
  logic           found;
  logic [R:0]     sel;

  // The low half holds only requests at or above ptr, the high half holds
  // all requests. The lowest set bit of the concatenation is therefore the
  // first requester at or after ptr, and dropping the top index bit folds
  // a hit in the high half back into the wrapped index.
  always_comb begin
    mask  = {N{1'b1}} << ptr;
    dbl   = {req, req & mask};
    found = 1'b0;
    sel   = '0;
    for (int i = 0; i < 2*N; i++) begin
      if (!found && dbl[i]) begin
        found = 1'b1;
        sel   = (R+1)'(i);
      end
    end
  end

  assign any    = |req;
  assign winner = sel[R-1:0];

endmodule

// File: rtl/parallel_lane_rr_arbiter.sv
// Shares one 2**S-bit lane between 2**R requesters with round-robin
// arbitration and bursts of up to 2**L words per grant.
// Ports:
//   clk, rst   - clock and synchronous active-high reset
//   req        - per-requester word valid
//   req_data   - flattened words, requester i at [i*2**S +: 2**S]
//   ack        - one-hot, marks the requester whose word is captured now
//   out_data   - registered lane word
//   out_valid  - out_data holds an unconsumed word
//   out_ready  - downstream consumes out_data this cycle
//   grant_id   - current or most recent lane owner
//   busy       - a burst is in progress
module parallel_lane_rr_arbiter
  import parallel_lane_rr_arbiter_pkg::*;
#(
  parameter int S = DEF_S,
  parameter int R = DEF_R,
  parameter int L = DEF_L
) (
  input  logic                                    clk,
  input  logic                                    rst,
  input  logic [req_count(R)-1:0]                 req,
  input  logic [req_count(R)*lane_width(S)-1:0]   req_data,
  output logic [req_count(R)-1:0]                 ack,
  output logic [lane_width(S)-1:0]                out_data,
  output logic                                    out_valid,
  input  logic                                    out_ready,
  output logic [R-1:0]                            grant_id,
  output logic                                    busy
);

  localparam int W     = lane_width(S);
  localparam int N     = req_count(R);
  localparam int CNT_W = cnt_width(L);
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(burst_limit(L));

  state_t           state;
  logic [R-1:0]     ptr;
  logic [CNT_W-1:0] count;
  logic             any;
  logic [R-1:0]     winner;
  logic             ld;
  logic             owner_req;
  logic             capture;
  logic             rel_lane;
  logic [R-1:0]     cap_idx;
  logic [W-1:0]     cap_word;

  rr_pick #(.R(R)) u_pick (
    .req    (req),
    .ptr    (ptr),
    .any    (any),
    .winner (winner)
  );

  // The output stage can take a word when it is empty or being drained
  assign ld        = !out_valid || out_ready;
  assign owner_req = req[grant_id];
  assign busy      = (state == BURST);

  // Decide whether a word is captured this cycle and from whom, and whether
  // the current owner gives up the lane. Capture and release never coincide:
  // release needs the owner's request low or the limit already reached.
  always_comb begin
    capture  = 1'b0;
    rel_lane = 1'b0;
    cap_idx  = grant_id;
    case (state)
      IDLE: begin
        cap_idx = winner;
        capture = any && ld;
      end
      BURST: begin
        capture  = owner_req && ld && (count < LIMIT);
        rel_lane = !owner_req || (ld && (count == LIMIT));
      end
      default: begin
        capture  = 1'b0;
        rel_lane = 1'b0;
      end
    endcase
  end

  // Select the captured requester's word from the flattened bus
  always_comb begin
    cap_word = '0;
    for (int i = 0; i < N; i++) begin
      if (cap_idx == R'(i)) begin
        cap_word = req_data[i*W +: W];
      end
    end
  end

  // Acknowledge goes only to the requester whose word is taken, and is
  // suppressed while reset is held so nothing is lost by a reset mid-burst
  always_comb begin
    ack = '0;
    if (capture && !rst) begin
      ack[cap_idx] = 1'b1;
    end
  end

  // Output register, burst counter, round-robin pointer and FSM. On release
  // the pointer moves just past the owner so it becomes lowest priority.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      out_valid <= 1'b0;
      out_data  <= '0;
      ptr       <= '0;
      grant_id  <= '0;
      count     <= '0;
    end else begin
      if (capture) begin
        out_data  <= cap_word;
        out_valid <= 1'b1;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
      case (state)
        IDLE: begin
          if (capture) begin
            grant_id <= winner;
            count    <= CNT_W'(1);
            state    <= BURST;
          end
        end
        BURST: begin
          if (rel_lane) begin
            ptr   <= grant_id + R'(1);
            state <= IDLE;
          end else if (capture) begin
            count <= count + CNT_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_parallel_lane_rr_arbiter.sv
// Randomized scoreboard bench for parallel_lane_rr_arbiter. A behavioural
// model predicts each cycle's acknowledge and pushes every captured word
// into a queue; a separate monitor pops and compares on each consumption.
module tb_parallel_lane_rr_arbiter;

  localparam int S     = 3;
  localparam int R     = 2;
  localparam int L     = 2;
  localparam int W     = 1 << S;
  localparam int N     = 1 << R;
  localparam int LIMIT = 1 << L;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [N-1:0]   req = '0;
  logic [N*W-1:0] req_data = '0;
  logic [N-1:0]   ack;
  logic [W-1:0]   out_data;
  logic           out_valid;
  logic           out_ready = 1'b0;
  logic [R-1:0]   grant_id;
  logic           busy;

  parallel_lane_rr_arbiter #(.S(S), .R(R), .L(L)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .req_data  (req_data),
    .ack       (ack),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .grant_id  (grant_id),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: lane owner (-1 when free), words taken this grant,
  // next priority index, last owner, output occupancy and last word.
  logic [W-1:0] exp_q[$];
  int           m_owner;
  int           m_taken;
  int           m_ptr;
  int           m_last;
  bit           m_valid;
  logic [W-1:0] m_data;
  bit           e_cap;
  bit           e_rel;
  int           e_idx;
  logic [N-1:0] e_ack;
  logic [W-1:0] mon_exp;

  task automatic compare(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic modelReset();
    m_owner = -1;
    m_taken = 0;
    m_ptr   = 0;
    m_last  = 0;
    m_valid = 0;
    m_data  = '0;
    exp_q.delete();
  endtask

  // Work out what should happen this cycle from the current inputs
  task automatic modelPredict();
    bit ld;
    ld    = !m_valid || out_ready;
    e_cap = 0;
    e_rel = 0;
    e_idx = 0;
    if (m_owner < 0) begin
      if (ld) begin
        for (int k = 0; k < N; k++) begin
          int c;
          c = (m_ptr + k) % N;
          if (!e_cap && req[c]) begin
            e_cap = 1;
            e_idx = c;
          end
        end
      end
    end else if (!req[m_owner]) begin
      e_rel = 1;
    end else if (ld) begin
      if (m_taken < LIMIT) begin
        e_cap = 1;
        e_idx = m_owner;
      end else begin
        e_rel = 1;
      end
    end
    e_ack = '0;
    if (e_cap) e_ack[e_idx] = 1'b1;
  endtask

  task automatic modelCommit();
    if (e_cap) begin
      m_data = req_data[e_idx*W +: W];
      exp_q.push_back(m_data);
      if (m_owner < 0) begin
        m_owner = e_idx;
        m_last  = e_idx;
        m_taken = 1;
      end else begin
        m_taken++;
      end
    end
    if (e_rel) begin
      m_ptr   = (m_owner + 1) % N;
      m_owner = -1;
    end
    if (e_cap) m_valid = 1;
    else if (out_ready) m_valid = 0;
  endtask

  task automatic applyStimulus(input logic [N-1:0] r, input logic [N*W-1:0] d, input logic rdy);
    @(posedge clk);
    #1;
    rst       = 1'b0;
    req       = r;
    req_data  = d;
    out_ready = rdy;
    modelPredict();
  endtask

  task automatic checkOutput();
    @(negedge clk);
    compare("ack", 32'(ack), 32'(e_ack));
    compare("out_valid", 32'(out_valid), 32'(m_valid));
    compare("out_data", 32'(out_data), 32'(m_data));
    compare("busy", 32'(busy), 32'(m_owner >= 0));
    compare("grant_id", 32'(grant_id), 32'(m_last));
    modelCommit();
  endtask

  // Hold reset with live requests; ack must stay low and state must clear
  task automatic doReset();
    @(posedge clk);
    #1;
    rst       = 1'b1;
    req       = N'($urandom);
    req_data  = (N*W)'({$urandom, $urandom});
    out_ready = 1'(($urandom));
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      compare("rst_ack", 32'(ack), 32'd0);
    end
    compare("rst_out_valid", 32'(out_valid), 32'd0);
    compare("rst_out_data", 32'(out_data), 32'd0);
    compare("rst_grant_id", 32'(grant_id), 32'd0);
    compare("rst_busy", 32'(busy), 32'd0);
    modelReset();
  endtask

  // Monitor: every consumed word must be the oldest predicted capture
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("[TB] FAIL consume: got %0h expected no word at %0t", out_data, $time);
      end else begin
        mon_exp = exp_q.pop_front();
        compare("consume", 32'(out_data), 32'(mon_exp));
      end
    end
  end

  initial begin
    logic [N-1:0]   r;
    logic [N*W-1:0] d;
    logic           rdy;

    modelReset();
    doReset();

    // Requester 2 alone: acked at once, word visible the next cycle
    applyStimulus(4'b0100, {8'h00, 8'hA5, 8'h00, 8'h00}, 1'b1);
    checkOutput();
    applyStimulus(4'b0000, '0, 1'b1);
    checkOutput();
    compare("first_word", 32'(out_data), 32'hA5);
    compare("first_grant", 32'(grant_id), 32'd2);

    // Requester 1 held through more words than the burst limit
    for (int i = 0; i < 7; i++) begin
      d = '0;
      d[W +: W] = W'(11 + i);
      applyStimulus(4'b0010, d, 1'b1);
      checkOutput();
    end

    // Backpressure on a full output stage, then release it
    for (int i = 0; i < 6; i++) begin
      applyStimulus(4'b1000, {8'(8'h30 + i), 24'h0}, (i == 5));
      checkOutput();
    end

    // Randomized traffic with sticky requests and occasional resets
    r = '0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if ($urandom_range(0, 199) == 0) begin
        doReset();
      end
      for (int b = 0; b < N; b++) begin
        if ($urandom_range(0, 4) == 0) r[b] = ($urandom_range(0, 9) < 6);
      end
      d   = (N*W)'({$urandom, $urandom});
      rdy = ($urandom_range(0, 3) != 0);
      applyStimulus(r, d, rdy);
      checkOutput();
    end

    // Drain the output stage; nothing predicted may remain unconsumed
    for (int i = 0; i < 8; i++) begin
      applyStimulus('0, '0, 1'b1);
      checkOutput();
    end
    compare("drained", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
